// File: rtl/fpdiv_pkg.sv
// Shared types and mux-select encodings for the Goldschmidt divider controller.
package fpdiv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MUL0,
    S_ITB,
    S_ITAC,
    S_RND,
    S_DONE
  } state_t;

  // Mux A: which operand feeds the multiplier's first input.
  localparam logic [1:0] SEL_A_FEEDBACK = 2'b00;
  localparam logic [1:0] SEL_A_ROUND    = 2'b01;
  localparam logic [1:0] SEL_A_OPERAND  = 2'b10;

  // Mux B: which operand feeds the multiplier's second input.
  localparam logic [1:0] SEL_B_DIVIDEND = 2'b00;
  localparam logic [1:0] SEL_B_DIVISOR  = 2'b01;
  localparam logic [1:0] SEL_B_TWOS     = 2'b10;
  localparam logic [1:0] SEL_B_FEEDBACK = 2'b11;

  typedef struct packed {
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic       en_a;
    logic       en_b;
    logic       en_c;
    logic       en_r;
  } ctrl_t;

  // Datapath selects/enables for the cycle spent in a given state.
  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_LOAD: begin
        c.sel_a = SEL_A_OPERAND;
        c.sel_b = SEL_B_DIVISOR;
        c.en_b  = 1'b1;
      end
      S_MUL0: begin
        c.sel_a = SEL_A_OPERAND;
        c.sel_b = SEL_B_DIVIDEND;
        c.en_a  = 1'b1;
        c.en_c  = 1'b1;
      end
      S_ITB: begin
        c.sel_a = SEL_A_FEEDBACK;
        c.sel_b = SEL_B_TWOS;
        c.en_b  = 1'b1;
      end
      S_ITAC: begin
        c.sel_a = SEL_A_FEEDBACK;
        c.sel_b = SEL_B_FEEDBACK;
        c.en_a  = 1'b1;
        c.en_c  = 1'b1;
      end
      S_RND: begin
        c.sel_a = SEL_A_ROUND;
        c.sel_b = SEL_B_TWOS;
        c.en_r  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/fpdiv_if.sv
// Bus between the divider controller and its surroundings (operands, datapath controls, result).
interface fpdiv_if;
  logic        start;
  logic [31:0] x_bits;
  logic [31:0] d_bits;
  logic        rne;
  logic [31:0] dp_result;

  logic [27:0] x;
  logic [27:0] d;
  logic [7:0]  x_exp;
  logic [7:0]  d_exp;
  logic        x_sign;
  logic        d_sign;
  logic [1:0]  sel_muxa;
  logic [1:0]  sel_muxb;
  logic        enA;
  logic        enB;
  logic        enC;
  logic        enR;
  logic        rMode;
  logic        busy;
  logic        done;
  logic [31:0] result;

  modport master (
    output start, x_bits, d_bits, rne, dp_result,
    input  x, d, x_exp, d_exp, x_sign, d_sign, sel_muxa, sel_muxb,
           enA, enB, enC, enR, rMode, busy, done, result
  );

  modport slave (
    input  start, x_bits, d_bits, rne, dp_result,
    output x, d, x_exp, d_exp, x_sign, d_sign, sel_muxa, sel_muxb,
           enA, enB, enC, enR, rMode, busy, done, result
  );
endinterface

// File: rtl/fpdiv_unpack.sv
// Splits an IEEE-754 single into sign, biased exponent and a 28-bit mantissa
// with explicit hidden one and four guard bits. Pure field extraction.
module fpdiv_unpack (
  input  logic [31:0] ieee_i,
  output logic [27:0] man_o,
  output logic [7:0]  exp_o,
  output logic        sign_o
);

  assign sign_o = ieee_i[31];
  assign exp_o  = ieee_i[30:23];
  assign man_o  = {1'b1, ieee_i[22:0], 4'b0000};

endmodule

// File: rtl/fpdiv_ctrl.sv
// Sequencer for a Goldschmidt divider: latches operands, steps the shared
// multiplier datapath through LOAD/MUL0/(ITB,ITAC)xITERS/ITB/RND and captures
// the quotient.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 3
) (
  input logic   clk,
  input logic   reset,
  fpdiv_if.slave bus
);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  ctrl_t       ctrl_q;
  logic        busy_q, done_q, rmode_q;
  logic [27:0] x_q, d_q;
  logic [7:0]  xexp_q, dexp_q;
  logic        xsign_q, dsign_q;
  logic [31:0] result_q;

  logic [27:0] x_man, d_man;
  logic [7:0]  x_e, d_e;
  logic        x_s, d_s;
  logic        accept;

  fpdiv_unpack u_unpack_x (
    .ieee_i (bus.x_bits),
    .man_o  (x_man),
    .exp_o  (x_e),
    .sign_o (x_s)
  );

  fpdiv_unpack u_unpack_d (
    .ieee_i (bus.d_bits),
    .man_o  (d_man),
    .exp_o  (d_e),
    .sign_o (d_s)
  );

  assign accept = (state_q == S_IDLE) && bus.start;

  // Next state and iteration count; every non-idle state lasts one cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_LOAD;
      S_LOAD: begin
        state_d = S_MUL0;
        cnt_d   = 3'd0;
      end
      S_MUL0: state_d = S_ITB;
      S_ITB:  state_d = (cnt_q == 3'(ITERS)) ? S_RND : S_ITAC;
      S_ITAC: begin
        state_d = S_ITB;
        cnt_d   = cnt_q + 3'd1;
      end
      S_RND:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State and ITAC-visit counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls are decoded from the next state so they are flop outputs valid for the whole state cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      ctrl_q <= decode_ctrl(state_d);
      busy_q <= (state_d != S_IDLE);
      done_q <= (state_d == S_DONE);
    end
  end

  // Operand and rounding-mode capture on acceptance; held until the next one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q     <= '0;
      d_q     <= '0;
      xexp_q  <= '0;
      dexp_q  <= '0;
      xsign_q <= 1'b0;
      dsign_q <= 1'b0;
      rmode_q <= 1'b0;
    end else if (accept) begin
      x_q     <= x_man;
      d_q     <= d_man;
      xexp_q  <= x_e;
      dexp_q  <= d_e;
      xsign_q <= x_s;
      dsign_q <= d_s;
      rmode_q <= bus.rne;
    end
  end

  // The rounded quotient is on dp_result during DONE; hold it until the next DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q <= '0;
    end else if (state_q == S_DONE) begin
      result_q <= bus.dp_result;
    end
  end

  assign bus.x        = x_q;
  assign bus.d        = d_q;
  assign bus.x_exp    = xexp_q;
  assign bus.d_exp    = dexp_q;
  assign bus.x_sign   = xsign_q;
  assign bus.d_sign   = dsign_q;
  assign bus.sel_muxa = ctrl_q.sel_a;
  assign bus.sel_muxb = ctrl_q.sel_b;
  assign bus.enA      = ctrl_q.en_a;
  assign bus.enB      = ctrl_q.en_b;
  assign bus.enC      = ctrl_q.en_c;
  assign bus.enR      = ctrl_q.en_r;
  assign bus.rMode    = rmode_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;

endmodule

// File: doc/fpdiv_ctrl.md
FPDIV_CTRL -- requirements
Module: fpdiv_ctrl

Interface
REQ-001 Parameter: ITERS, default 3, number of Goldschmidt refinement iterations (legal range 1..7).
REQ-002 Port: clk  in  1  rising-edge clock; the block has one clock domain only.
REQ-003 Port: reset  in  1  asynchronous, active-low reset.
REQ-004 Port: start  in  1  request pulse; sampled only in IDLE.
REQ-005 Port: x_bits, d_bits  in  32 each  IEEE-754 single dividend and divisor.
REQ-006 Port: rne  in  1  rounding-mode request, latched at start.
REQ-007 Port: dp_result  in  32  datapath resultOut.
REQ-008 Port: x, d  out  28 each  unpacked mantissas {1'b1, frac[22:0], 4'b0}.
REQ-009 Port: x_exp, d_exp  out  8 each; x_sign, d_sign  out  1 each.
REQ-010 Port: sel_muxa, sel_muxb  out  2 each  datapath mux selects.
REQ-011 Port: enA, enB, enC, enR  out  1 each  datapath register enables.
REQ-012 Port: rMode  out  1  latched rounding mode.
REQ-013 Port: busy  out  1  high from the cycle after start acceptance until DONE is left.
REQ-014 Port: done  out  1  one-cycle completion pulse.
REQ-015 Port: result  out  32  captured quotient.

Function
REQ-016 States: IDLE, LOAD, MUL0, ITB, ITAC, RND, DONE.
REQ-017 IDLE with start=1 SHALL register operands and rne, then go to LOAD; operand outputs stay stable until the next acceptance.
REQ-018 Each state SHALL last exactly one clock; its selects and enables are registered outputs valid for that whole cycle.
REQ-019 LOAD: sel_muxa=10, sel_muxb=01, enB=1.
REQ-020 MUL0: sel_muxa=10, sel_muxb=00, enA=enC=1.
REQ-021 ITB: sel_muxa=00, sel_muxb=10, enB=1.
REQ-022 ITAC: sel_muxa=00, sel_muxb=11, enA=enC=1.
REQ-023 RND: sel_muxa=01, sel_muxb=10, enR=1.
REQ-024 Order SHALL be LOAD, MUL0, then (ITB, ITAC) ITERS times, then ITB, RND, DONE. A 3-bit counter counts ITAC visits; ITB goes to RND once count==ITERS.
REQ-025 Enables not listed for a state SHALL be 0; in IDLE and DONE all enables are 0 and the selects are 00.
REQ-026 DONE: result<=dp_result, done=1, next state IDLE. Latency from acceptance edge to done is 2*ITERS+5 cycles (11 for ITERS=3).
REQ-027 start while busy SHALL be ignored; start held high SHALL start a new operation in the IDLE cycle after DONE.
REQ-028 result SHALL hold its value until the next DONE.
REQ-029 Operand outputs SHALL be pure field extraction; no special-case handling of zero, Inf or NaN in this block.

Reset
REQ-030 reset low SHALL asynchronously force IDLE, counter=0, and busy, done, all enables, rMode, selects, x, d, exponents, signs and result to 0.
REQ-031 Reset mid-operation SHALL abort the operation with no enable pulse after reset assertion; the next start after release runs a full sequence.

Structure
REQ-032 A shared package fpdiv_pkg SHALL hold the state enum and select encodings (SEL_A_*, SEL_B_*).
REQ-033 One sub-module, fpdiv_unpack (combinational IEEE-to-mantissa/exp/sign split), SHALL be instantiated twice.
REQ-034 Top-level integration connects fpdiv_ctrl outputs directly to the fpdiv ports of the same names.

Verification
REQ-035 x_bits=3FC00000, d_bits=3F800000, start 1 cycle -> x=0x C000000, d=0x8000000, x_exp=d_exp=7F; states LOAD,MUL0,(ITB,ITAC)x3,ITB,RND; done on cycle 11.
REQ-036 dp_result stubbed to 3FC00000 -> result=3FC00000 after done and held for 20 further idle cycles.
REQ-037 start pulsed in cycles 3 and 7 of an operation -> sequence unchanged; exactly one done.
REQ-038 reset asserted in ITAC -> outputs 0 immediately; after release, start gives a full 11-cycle run.
REQ-039 ITERS=1 -> LOAD,MUL0,ITB,ITAC,ITB,RND; done on cycle 7.
REQ-040 start held high for 30 cycles -> back-to-back operations, done every 12 cycles, rMode equal to rne at each acceptance.
